fir_frame_tx: RTL and testbench

- Transmit-side companion to the FIR block's sample-count logic. It produces the `fir_valid`-qualified sample stream that the downstream 16-sample frame counter consumes.
- It collects FRAME_LEN samples from an upstream producer into a local buffer, then streams them out as one back-to-back frame with a valid/ready handshake.
- The last sample of each frame is marked, so the frame boundary seen by the downstream counter matches the one the transmitter intended.
- It sits between the sample source and the FIR datapath input.

---
 rtl/fir_frame_tx.sv | 71 +++++++
 tb/tb_fir_frame_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fir_frame_tx.sv
// fir_frame_tx: buffers FRAME_LEN samples, then streams them out as one frame marking the last sample.
module fir_frame_tx #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              fir_valid,
  output logic [DATA_W-1:0] fir_data,
  output logic              fir_last,
  input  logic              fir_ready,
  output logic [7:0]        frame_cnt,
  output logic              busy
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [DATA_W-1:0] buf_q [FRAME_LEN];
  logic              in_xfer, out_xfer;
  assign in_ready  = state_q == FILL;
  assign fir_valid = state_q == SEND;
  assign busy      = fir_valid;
  assign fir_data  = buf_q[rd_idx_q];
  assign fir_last  = fir_valid && rd_idx_q == LAST;
  assign frame_cnt = frame_cnt_q;
  // clr masks both handshakes so an aborted cycle leaves no trace
  assign in_xfer  = in_valid && in_ready && !clr;
  assign out_xfer = fir_valid && fir_ready && !clr;
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    frame_cnt_d = frame_cnt_q;
    if (clr) begin
      state_d  = FILL;
      wr_idx_d = '0;
      rd_idx_d = '0;
    end else if (in_xfer) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
      state_d  = wr_idx_q == LAST ? SEND : FILL;
    end else if (out_xfer) begin
      rd_idx_d    = rd_idx_q + IDX_W'(1);
      state_d     = fir_last ? FILL : SEND;
      frame_cnt_d = fir_last ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_xfer) buf_q[wr_idx_q] <= in_data;
  end
endmodule

// File: tb/tb_fir_frame_tx.sv
// tb_fir_frame_tx: vector table plus queue scoreboard for fir_frame_tx.
module tb_fir_frame_tx;
  typedef struct {
    logic [15:0] din;
    logic [15:0] exp_data;
    logic        exp_last;
  } vec_t;
  logic        clk = 0, rst = 1, clr = 0, in_valid = 0, fir_ready = 0;
  logic [15:0] in_data = 0;
  logic        in_ready, fir_valid, fir_last, busy;
  logic [15:0] fir_data;
  logic [7:0]  frame_cnt;
  int          n_chk = 0, n_fail = 0;
  logic [15:0] q[$];
  logic        m_send = 0, stall = 0, pl = 0;
  logic [15:0] pd = 0;
  logic [7:0]  m_cnt = 0;
  logic [3:0]  dc = 0;
  int          m_wr = 0;
  vec_t        vt[16];
  fir_frame_tx #(.DATA_W(16), .FRAME_LEN(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fir_valid(fir_valid), .fir_data(fir_data),
    .fir_last(fir_last), .fir_ready(fir_ready), .frame_cnt(frame_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic feed(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data  = base + 16'(i);
      tick();
    end
    in_valid = 0;
  endtask
  task automatic wait_cnt(input logic [7:0] t, input int budget, input string nm);
    for (int n = 0; n < budget && frame_cnt !== t; n++) tick();
    chk(nm, frame_cnt, t);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      m_send = 0; m_wr = 0; m_cnt = 0; dc = 0; q.delete();
    end
    chk("in_ready", in_ready, !m_send);
    chk("fir_valid", fir_valid, m_send);
    chk("busy", busy, m_send);
    chk("frame_cnt", frame_cnt, m_cnt);
    if (m_send && q.size() > 0) begin
      chk("fir_data", fir_data, q[0]);
      chk("fir_last", fir_last, q.size() == 1);
    end else chk("fir_last_idle", fir_last, 0);
    if (stall && fir_valid) begin
      chk("hold_data", fir_data, pd);
      chk("hold_last", fir_last, pl);
    end
    stall = fir_valid && !fir_ready;
    pd = fir_data;
    pl = fir_last;
    if (fir_valid && fir_ready && !clr && !rst) begin
      chk("ds_tc", fir_last, dc == 4'd15);
      dc = dc + 4'd1;
    end
    if (!rst) begin
      if (clr) begin
        m_send = 0; m_wr = 0; dc = 0; stall = 0; q.delete();
      end else if (!m_send && in_valid) begin
        q.push_back(in_data);
        m_wr++;
        if (m_wr == 16) begin m_send = 1; m_wr = 0; end
      end else if (m_send && fir_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) begin m_send = 0; m_cnt++; end
      end
    end
  end
  initial begin
    for (int i = 0; i < 16; i++) vt[i] = '{16'(i + 1), 16'(i + 1), i == 15};
    repeat (3) tick();
    rst = 0;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_fir_valid", fir_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_frame_cnt", frame_cnt, 0);
    fir_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data  = vt[i].din;
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 16; i++) begin
      chk("t2_valid", fir_valid, 1);
      chk("t2_data", fir_data, vt[i].exp_data);
      chk("t2_last", fir_last, vt[i].exp_last);
      tick();
    end
    chk("t2_valid_end", fir_valid, 0);
    chk("t2_in_ready", in_ready, 1);
    chk("t2_frame_cnt", frame_cnt, 1);
    fir_ready = 0;
    for (int sent = 0; sent < 16;) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'h0200 + 16'(sent);
      tick();
      if (in_valid) sent++;
    end
    for (int n = 0; n < 200 && frame_cnt !== 8'd2; n++) begin
      fir_ready = ~fir_ready;
      in_valid  = 1;
      in_data   = 16'($urandom);
      tick();
    end
    chk("t3_done", frame_cnt, 2);
    in_valid = 0;
    fir_ready = 1;
    feed(16'h0050, 7);
    clr = 1;
    in_valid = 1;
    in_data = 16'hdead;
    tick();
    clr = 0;
    in_valid = 0;
    tick();
    chk("t4a_no_out", fir_valid, 0);
    feed(16'h0100, 16);
    chk("t4a_first", fir_data, 16'h0100);
    wait_cnt(8'd3, 40, "t4a_done");
    feed(16'h0400, 16);
    repeat (15) tick();
    chk("t4b_at_last", fir_last, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("t4b_cnt_held", frame_cnt, 3);
    chk("t4b_fill", in_ready, 1);
    chk("t4b_no_valid", fir_valid, 0);
    feed(16'h0500, 16);
    repeat (5) tick();
    rst = 1;
    #1;
    chk("t5_valid_drop", fir_valid, 0);
    chk("t5_cnt_zero", frame_cnt, 0);
    tick();
    rst = 0;
    feed(16'h0300, 16);
    chk("t5_first", fir_data, 16'h0300);
    wait_cnt(8'd1, 40, "t5_done");
    rst = 1;
    tick();
    rst = 0;
    in_valid = 1;
    for (int n = 0; n < 257 * 32; n++) begin
      in_data = 16'(n);
      tick();
    end
    in_valid = 0;
    chk("t6_wrap", frame_cnt, 1);
    tick();
    chk("t6_idle", fir_valid, 0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
